// File: rtl/sin400k.sv
// Two-channel time-multiplexed NCO: 32-bit phase accumulators, 12-bit phase address,
// quarter-wave sine table, 14-bit sine/cosine outputs, 4-stage pipeline after the phase sample.
module sin400k (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clken,
  input  logic [31:0]        phi_inc_i,
  output logic signed [13:0] fsin_o,
  output logic signed [13:0] fcos_o,
  output logic               out_valid
);

  localparam int DATA_W  = 14;
  localparam int PHASE_W = 32;
  localparam int ADDR_W  = 12;
  localparam int QTR     = 1024;

  // Exact round-half-away of 8191*sin(pi*a/2048) for the first quadrant, evaluated at
  // elaboration with a Q60 Taylor series so every table entry is bit-exact.
  function automatic logic [12:0] quarter_sin(input logic [10:0] a);
    logic [127:0] x;
    logic [127:0] x2;
    logic [127:0] term;
    logic [127:0] sum;
    logic [127:0] y;
    x    = (128'(a) * 128'h3243F6A8885A308D) >> 11;
    x2   = (x * x) >> 60;
    term = x;
    sum  = x;
    for (int k = 1; k <= 13; k++) begin
      term = ((term * x2) >> 60) / 128'((2 * k) * (2 * k + 1));
      if (k % 2 == 1) sum = sum - term;
      else            sum = sum + term;
    end
    y = sum * 128'd8191 + (128'd1 << 59);
    return 13'(y >> 60);
  endfunction

  // Mirror the in-quadrant index for the 2nd and 4th quadrants.
  function automatic logic [10:0] fold_idx(input logic [ADDR_W-1:0] a);
    return a[10] ? (11'd1024 - {1'b0, a[9:0]}) : {1'b0, a[9:0]};
  endfunction

  function automatic logic signed [DATA_W-1:0] apply_sign(input logic neg, input logic [12:0] mag);
    logic signed [DATA_W-1:0] m;
    m = $signed({1'b0, mag});
    return neg ? -m : m;
  endfunction

  logic [12:0] qrom [0:QTR];

  for (genvar i = 0; i <= QTR; i++) begin : g_rom
    localparam logic [12:0] QVAL = quarter_sin(11'(i));
    assign qrom[i] = QVAL;
  end

  logic                     ch;
  logic [PHASE_W-1:0]       acc [2];

  logic [ADDR_W-1:0]        addr_p0;
  logic                     vld_p0;

  logic [10:0]              idx_s_p1;
  logic [10:0]              idx_c_p1;
  logic                     neg_s_p1;
  logic                     neg_c_p1;
  logic                     vld_p1;

  logic [12:0]              mag_s_p2;
  logic [12:0]              mag_c_p2;
  logic                     neg_s_p2;
  logic                     neg_c_p2;
  logic                     vld_p2;

  logic signed [DATA_W-1:0] sin_p3;
  logic signed [DATA_W-1:0] cos_p3;
  logic                     vld_p3;

  logic [ADDR_W-1:0]        addr_c;

  // Cosine is the sine a quarter turn ahead.
  assign addr_c = addr_p0 + 12'h400;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ch        <= 1'b0;
      acc[0]    <= '0;
      acc[1]    <= '0;
      addr_p0   <= '0;
      vld_p0    <= 1'b0;
      idx_s_p1  <= '0;
      idx_c_p1  <= '0;
      neg_s_p1  <= 1'b0;
      neg_c_p1  <= 1'b0;
      vld_p1    <= 1'b0;
      mag_s_p2  <= '0;
      mag_c_p2  <= '0;
      neg_s_p2  <= 1'b0;
      neg_c_p2  <= 1'b0;
      vld_p2    <= 1'b0;
      sin_p3    <= '0;
      cos_p3    <= '0;
      vld_p3    <= 1'b0;
      fsin_o    <= '0;
      fcos_o    <= '0;
      out_valid <= 1'b0;
    end else if (clken) begin
      // p0: sample the pre-add phase of the serviced channel
      ch      <= ~ch;
      acc[ch] <= acc[ch] + phi_inc_i;
      addr_p0 <= acc[ch][PHASE_W-1 -: ADDR_W];
      vld_p0  <= 1'b1;

      // p1: quadrant fold
      idx_s_p1 <= fold_idx(addr_p0);
      idx_c_p1 <= fold_idx(addr_c);
      neg_s_p1 <= addr_p0[ADDR_W-1];
      neg_c_p1 <= addr_c[ADDR_W-1];
      vld_p1   <= vld_p0;

      // p2: table lookup
      mag_s_p2 <= qrom[idx_s_p1];
      mag_c_p2 <= qrom[idx_c_p1];
      neg_s_p2 <= neg_s_p1;
      neg_c_p2 <= neg_c_p1;
      vld_p2   <= vld_p1;

      // p3: restore sign
      sin_p3 <= apply_sign(neg_s_p2, mag_s_p2);
      cos_p3 <= apply_sign(neg_c_p2, mag_c_p2);
      vld_p3 <= vld_p2;

      // Output register; data stays at zero until the first valid sample arrives.
      if (vld_p3) begin
        fsin_o <= sin_p3;
        fcos_o <= cos_p3;
      end
      out_valid <= vld_p3;
    end
  end

endmodule

// File: tb/tb_sin400k.sv
// Directed vector table plus a modelled streaming run for the two-channel NCO.
module tb_sin400k;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               clken;
  logic [31:0]        phi_inc_i;
  logic signed [13:0] fsin_o;
  logic signed [13:0] fcos_o;
  logic               out_valid;

  int nvec = 0;
  int nerr = 0;

  sin400k dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .clken     (clken),
    .phi_inc_i (phi_inc_i),
    .fsin_o    (fsin_o),
    .fcos_o    (fcos_o),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rst_n;
    bit          en;
    logic [31:0] phi;
    bit          chk_d;
    bit          v;
    int          s;
    int          c;
  } vec_t;

  vec_t vecs[$];

  localparam logic [31:0] P0 = 32'h0EBEDFA4;
  localparam logic [31:0] P1 = 32'h075F6FD2;
  localparam logic [31:0] PQ = 32'h40000000;
  localparam real         PI = 3.14159265358979323846;

  function automatic int rnd_away(input real v);
    if (v >= 0.0) return $rtoi(v + 0.5);
    else          return -$rtoi(-v + 0.5);
  endfunction

  function automatic int ref_sin(input int a);
    return rnd_away(8191.0 * $sin(2.0 * PI * $itor(a) / 4096.0));
  endfunction

  function automatic int ref_cos(input int a);
    return rnd_away(8191.0 * $cos(2.0 * PI * $itor(a) / 4096.0));
  endfunction

  task automatic add(input bit r, input bit e, input logic [31:0] p,
                     input bit cd, input bit v, input int s, input int c);
    vec_t t;
    t.rst_n = r; t.en = e; t.phi = p; t.chk_d = cd; t.v = v; t.s = s; t.c = c;
    vecs.push_back(t);
  endtask

  // Start-up after reset release with the alternating ch0/ch1 increments.
  task automatic add_startup();
    add(1, 1, P0, 0, 0, 0, 0);
    add(1, 1, P1, 0, 0, 0, 0);
    add(1, 1, P0, 0, 0, 0, 0);
    add(1, 1, P1, 0, 0, 0, 0);
    add(1, 1, P0, 1, 1, 0, 8191);
    add(1, 1, P1, 1, 1, 0, 8191);
    add(1, 1, P0, 1, 1, 2889, 7665);
  endtask

  task automatic tick(input bit r, input bit e, input logic [31:0] p);
    reset_n   = r;
    clken     = e;
    phi_inc_i = p;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input bit chk_d, input bit ev, input int es, input int ec);
    logic signed [13:0] s14;
    logic signed [13:0] c14;
    s14 = 14'(es);
    c14 = 14'(ec);
    nvec++;
    if (out_valid !== ev) begin
      nerr++;
      $display("FAIL %s out_valid got %0b want %0b", nm, out_valid, ev);
    end
    if (chk_d && (fsin_o !== s14)) begin
      nerr++;
      $display("FAIL %s fsin_o got %0d want %0d", nm, fsin_o, s14);
    end
    if (chk_d && (fcos_o !== c14)) begin
      nerr++;
      $display("FAIL %s fcos_o got %0d want %0d", nm, fcos_o, c14);
    end
  endtask

  initial begin
    logic [31:0] macc [2];
    bit          mch;
    int          hist[$];
    int          n;
    bit          r;
    bit          e;
    logic [31:0] p;

    reset_n   = 1'b0;
    clken     = 1'b1;
    phi_inc_i = '0;

    // Power-on reset held for 7 edges
    repeat (7) add(0, 1, P0, 1, 0, 0, 0);
    add_startup();
    // Reset wins over clken low
    add(0, 0, PQ, 1, 0, 0, 0);
    // Quarter-turn increment on both channels, with a 3-cycle clken drop mid-stream
    repeat (4) add(1, 1, PQ, 0, 0, 0, 0);
    add(1, 1, PQ, 1, 1, 0, 8191);
    add(1, 1, PQ, 1, 1, 0, 8191);
    add(1, 1, PQ, 1, 1, 8191, 0);
    add(1, 1, PQ, 1, 1, 8191, 0);
    repeat (3) add(1, 0, 32'hFFFFFFFF, 1, 1, 8191, 0);
    add(1, 1, PQ, 1, 1, 0, -8191);
    add(1, 1, PQ, 1, 1, 0, -8191);
    add(1, 1, PQ, 1, 1, -8191, 0);
    add(1, 1, PQ, 1, 1, -8191, 0);
    add(1, 1, PQ, 1, 1, 0, 8191);
    add(1, 1, PQ, 1, 1, 0, 8191);
    add(1, 1, PQ, 1, 1, 8191, 0);
    add(1, 1, PQ, 1, 1, 8191, 0);
    // Zero increment
    add(0, 1, 32'h0, 1, 0, 0, 0);
    repeat (4) add(1, 1, 32'h0, 0, 0, 0, 0);
    repeat (4) add(1, 1, 32'h0, 1, 1, 0, 8191);
    // One-edge reset mid-stream, then the start-up sequence again
    add(0, 1, P0, 1, 0, 0, 0);
    add_startup();

    foreach (vecs[i]) begin
      tick(vecs[i].rst_n, vecs[i].en, vecs[i].phi);
      check($sformatf("vec%0d", i), vecs[i].chk_d, vecs[i].v, vecs[i].s, vecs[i].c);
    end

    // Modelled stream: random increments, random clken, one reset in the middle
    tick(0, 1, 32'h0);
    check("stream_rst", 1, 0, 0, 0);
    macc[0] = '0;
    macc[1] = '0;
    mch     = 1'b0;
    n       = 0;
    hist.delete();
    for (int i = 0; i < 300; i++) begin
      r = (i != 170);
      e = ($urandom_range(0, 3) != 0);
      p = $urandom;
      tick(r, e, p);
      if (!r) begin
        macc[0] = '0;
        macc[1] = '0;
        mch     = 1'b0;
        n       = 0;
        hist.delete();
        check($sformatf("stream%0d", i), 1, 0, 0, 0);
      end else begin
        if (e) begin
          hist.push_back(int'(macc[mch][31:20]));
          macc[mch] = macc[mch] + p;
          mch = ~mch;
          n++;
        end
        if (n >= 5)
          check($sformatf("stream%0d", i), 1, 1, ref_sin(hist[n-5]), ref_cos(hist[n-5]));
        else
          check($sformatf("stream%0d", i), 0, 0, 0, 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
